// File: rtl/spi_stream_receiver.sv
// SPI slave receiver: synchronises the pins, deserialises words, tags them as
// command or payload and queues the tagged words in a small output FIFO.
module spi_stream_receiver #(
    parameter int                DATA_W     = 8,
    parameter int                CPOL       = 0,
    parameter int                CPHA       = 0,
    parameter int                MSB_FIRST  = 1,
    parameter int                IDX_W      = 16,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] CMD_A      = 8'h01,
    parameter int                LEN_A      = 513,
    parameter logic [DATA_W-1:0] CMD_B      = 8'h02,
    parameter int                LEN_B      = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs_n_i,
    input  logic              sck_i,
    input  logic              mosi_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_is_cmd_o,
    output logic [DATA_W-1:0] out_command_o,
    output logic [IDX_W-1:0]  out_index_o,
    output logic              overflow_o,
    output logic              frame_error_o
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 1 + 2 * DATA_W + IDX_W;
    localparam logic SCK_IDLE    = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic SAMPLE_RISE = (CPOL == CPHA) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_A   = IDX_W'(LEN_A - 1);
    localparam logic [IDX_W-1:0] LAST_B   = IDX_W'(LEN_B - 1);
    localparam logic [PTR_W:0]   DEPTH_V  = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_CMD = 1'b0, ST_PAYLOAD = 1'b1} state_t;

    logic [1:0]        cs_sync_q, sck_sync_q, mosi_sync_q;
    logic              cs_prev_q, sck_prev_q;
    logic              cs_s, sck_s, mosi_s, cs_rise_s, sample_edge_s;
    logic [DATA_W-1:0] shift_q, shifted_s;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              word_valid_q;
    state_t            state_q;
    logic [DATA_W-1:0] cmd_q;
    logic [IDX_W-1:0]  idx_q, last_q;
    logic [ENT_W-1:0]  ent_s, head_d;
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_q, rd_q, rd_d;
    logic [PTR_W:0]    count_q, count_d, remain_s;
    logic              pop_s, push_ok_s;

    assign cs_s      = cs_sync_q[1];
    assign sck_s     = sck_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign cs_rise_s = cs_s & ~cs_prev_q;
    assign sample_edge_s = ~cs_s & (SAMPLE_RISE ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q));

    // Pin synchronisers and edge-history flops
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync_q   <= 2'b11;
            sck_sync_q  <= {2{SCK_IDLE}};
            mosi_sync_q <= 2'b00;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= SCK_IDLE;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], cs_n_i};
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    // Next shifter contents for the configured bit order
    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted_s = {shift_q[DATA_W-2:0], mosi_s};
        end else begin
            shifted_s = {mosi_s, shift_q[DATA_W-1:1]};
        end
    end

    // Deserialiser; a partial word is simply abandoned by clearing the bit count
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q       <= {DATA_W{1'b0}};
            bit_cnt_q     <= {CNT_W{1'b0}};
            word_valid_q  <= 1'b0;
            frame_error_o <= 1'b0;
        end else begin
            word_valid_q  <= 1'b0;
            frame_error_o <= 1'b0;
            if (cs_s) begin
                bit_cnt_q     <= {CNT_W{1'b0}};
                frame_error_o <= cs_rise_s & (bit_cnt_q != {CNT_W{1'b0}});
            end else if (sample_edge_s) begin
                shift_q <= shifted_s;
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_q    <= {CNT_W{1'b0}};
                    word_valid_q <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Framing parser; advances even when the FIFO drops the word
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CMD;
            cmd_q   <= {DATA_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            last_q  <= {IDX_W{1'b0}};
        end else if (cs_rise_s) begin
            state_q <= ST_CMD;
            idx_q   <= {IDX_W{1'b0}};
        end else if (word_valid_q) begin
            case (state_q)
                ST_CMD: begin
                    cmd_q <= shift_q;
                    idx_q <= {IDX_W{1'b0}};
                    if (shift_q == CMD_A && LEN_A > 0) begin
                        state_q <= ST_PAYLOAD;
                        last_q  <= LAST_A;
                    end else if (shift_q == CMD_B && LEN_B > 0) begin
                        state_q <= ST_PAYLOAD;
                        last_q  <= LAST_B;
                    end else begin
                        state_q <= ST_CMD;
                    end
                end
                ST_PAYLOAD: begin
                    if (idx_q == last_q) begin
                        state_q <= ST_CMD;
                        idx_q   <= {IDX_W{1'b0}};
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= ST_CMD;
            endcase
        end
    end

    // Tagged entry for the word just completed
    always_comb begin
        if (state_q == ST_CMD) begin
            ent_s = {1'b1, shift_q, shift_q, {IDX_W{1'b0}}};
        end else begin
            ent_s = {1'b0, shift_q, cmd_q, idx_q};
        end
    end

    assign pop_s     = out_valid_o & out_ready_i;
    assign push_ok_s = word_valid_q & ((count_q != DEPTH_V) | pop_s);
    assign remain_s  = count_q - (PTR_W + 1)'(pop_s);

    // Next FIFO occupancy and next head; an empty FIFO keeps the last head
    always_comb begin
        count_d = remain_s + (PTR_W + 1)'(push_ok_s);
        rd_d    = rd_q + PTR_W'(pop_s);
        if (count_d == {(PTR_W + 1){1'b0}}) begin
            head_d = {out_is_cmd_o, out_data_o, out_command_o, out_index_o};
        end else if (remain_s == {(PTR_W + 1){1'b0}}) begin
            head_d = ent_s;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= ent_s;
        end
    end

    // FIFO pointers, registered head outputs and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q          <= {PTR_W{1'b0}};
            rd_q          <= {PTR_W{1'b0}};
            count_q       <= {(PTR_W + 1){1'b0}};
            out_valid_o   <= 1'b0;
            out_is_cmd_o  <= 1'b0;
            out_data_o    <= {DATA_W{1'b0}};
            out_command_o <= {DATA_W{1'b0}};
            out_index_o   <= {IDX_W{1'b0}};
            overflow_o    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_q <= wr_q + PTR_W'(1);
            end
            rd_q        <= rd_d;
            count_q     <= count_d;
            out_valid_o <= (count_d != {(PTR_W + 1){1'b0}});
            {out_is_cmd_o, out_data_o, out_command_o, out_index_o} <= head_d;
            if (word_valid_q & ~push_ok_s) begin
                overflow_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_stream_receiver.sv
// Bench for spi_stream_receiver: randomized SPI traffic scored against a
// framing model (remaining-length counter plus FIFO occupancy queue).
module tb_spi_stream_receiver;
    localparam int HALF = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cs_n [3];
    logic sck  [3];
    logic mosi [3];
    logic rdy0;
    logic       v0, ic0, ov0, fe0, v1, ic1, ov1, fe1, v2, ic2, ov2, fe2;
    logic [7:0] d0, c0, d1, c1, d2, c2;
    logic [15:0] i0, i1, i2;

    always #5 clock = ~clock;

    spi_stream_receiver dut0 (
        .clock(clock), .reset(reset), .cs_n_i(cs_n[0]), .sck_i(sck[0]), .mosi_i(mosi[0]),
        .out_ready_i(rdy0), .out_valid_o(v0), .out_data_o(d0), .out_is_cmd_o(ic0),
        .out_command_o(c0), .out_index_o(i0), .overflow_o(ov0), .frame_error_o(fe0));

    spi_stream_receiver #(.CPOL(1), .CPHA(1)) dut1 (
        .clock(clock), .reset(reset), .cs_n_i(cs_n[1]), .sck_i(sck[1]), .mosi_i(mosi[1]),
        .out_ready_i(1'b0), .out_valid_o(v1), .out_data_o(d1), .out_is_cmd_o(ic1),
        .out_command_o(c1), .out_index_o(i1), .overflow_o(ov1), .frame_error_o(fe1));

    spi_stream_receiver #(.MSB_FIRST(0)) dut2 (
        .clock(clock), .reset(reset), .cs_n_i(cs_n[2]), .sck_i(sck[2]), .mosi_i(mosi[2]),
        .out_ready_i(1'b0), .out_valid_o(v2), .out_data_o(d2), .out_is_cmd_o(ic2),
        .out_command_o(c2), .out_index_o(i2), .overflow_o(ov2), .frame_error_o(fe2));

    typedef struct packed {
        logic        is_cmd;
        logic [7:0]  data;
        logic [7:0]  cmd;
        logic [15:0] idx;
    } ent_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   fe_cnt [3];
    ent_t exp_q [$];
    int   rem = 0;
    int   nidx = 0;
    logic [7:0] cur = 8'h00;
    logic exp_ovf = 1'b0;

    // Count cycles with frame_error high on each instance
    always @(negedge clock) begin
        if (fe0) fe_cnt[0] = fe_cnt[0] + 1;
        if (fe1) fe_cnt[1] = fe_cnt[1] + 1;
        if (fe2) fe_cnt[2] = fe_cnt[2] + 1;
    end

    // Scoreboard: every handshake on the main instance must match the model queue
    always @(negedge clock) begin
        if (!reset && v0 && rdy0) begin
            vectors = vectors + 1;
            assert (exp_q.size() != 0) else begin
                miscompares = miscompares + 1;
                $error("FAIL pop_unexpected: got data=%h is_cmd=%0d, expected no entry", d0, ic0);
            end
            if (exp_q.size() != 0) begin
                ent_t e;
                ent_t got;
                e = exp_q.pop_front();
                got = '{is_cmd: ic0, data: d0, cmd: c0, idx: i0};
                vectors = vectors + 1;
                assert (got === e) else begin
                    miscompares = miscompares + 1;
                    $error("FAIL pop_entry: got cmd=%0d data=%h command=%h idx=%0d expected cmd=%0d data=%h command=%h idx=%0d",
                           got.is_cmd, got.data, got.cmd, got.idx, e.is_cmd, e.data, e.cmd, e.idx);
                end
            end
        end
    end

    function automatic int len_of(input logic [7:0] w);
        if (w == 8'h01) return 513;
        else if (w == 8'h02) return 6;
        else return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (got === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_word(input logic [7:0] w);
        ent_t e;
        if (rem == 0) begin
            e = '{is_cmd: 1'b1, data: w, cmd: w, idx: 16'd0};
            rem = len_of(w);
            cur = w;
            nidx = 0;
        end else begin
            e = '{is_cmd: 1'b0, data: w, cmd: cur, idx: 16'(nidx)};
            nidx = nidx + 1;
            rem = rem - 1;
        end
        if (exp_q.size() < 4) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic hwait();
        repeat (HALF) @(posedge clock);
        #2;
    endtask

    // Wire-level transfer; the model is updated just before the last sample edge
    task automatic send_word(input int u, input logic [7:0] w, input bit msb, input int nbits);
        bit mode3;
        mode3 = (u == 1);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = msb ? w[7 - i] : w[i];
            if (!mode3) begin
                mosi[u] = b;
                hwait();
                if (u == 0 && i == 7) model_word(w);
                sck[u] = 1'b1;
                hwait();
                sck[u] = 1'b0;
            end else begin
                sck[u] = 1'b0;
                mosi[u] = b;
                hwait();
                if (u == 0 && i == 7) model_word(w);
                sck[u] = 1'b1;
                hwait();
            end
        end
        hwait();
    endtask

    task automatic send(input logic [7:0] w);
        send_word(0, w, 1'b1, 8);
    endtask

    task automatic cs_down(input int u);
        cs_n[u] = 1'b0;
        hwait();
    endtask

    task automatic cs_up(input int u);
        cs_n[u] = 1'b1;
        if (u == 0) rem = 0;
        hwait();
        hwait();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || v0) && n < 500) begin
            @(posedge clock);
            n = n + 1;
        end
        #2;
        chk(tag, {31'd0, (exp_q.size() == 0 && !v0)}, 32'd1);
    endtask

    initial begin
        logic [7:0] w;
        fe_cnt = '{0, 0, 0};
        cs_n = '{1'b1, 1'b1, 1'b1};
        sck  = '{1'b0, 1'b1, 1'b0};
        mosi = '{1'b0, 1'b0, 1'b0};
        rdy0 = 1'b1;
        repeat (4) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("rst_valid", {31'd0, v0}, 32'd0);
        chk("rst_data", {24'd0, d0}, 32'd0);
        chk("rst_is_cmd", {31'd0, ic0}, 32'd0);
        chk("rst_command", {24'd0, c0}, 32'd0);
        chk("rst_index", {16'd0, i0}, 32'd0);
        chk("rst_overflow", {31'd0, ov0}, 32'd0);
        chk("rst_frame_error", {31'd0, fe0}, 32'd0);
        @(posedge clock);
        #2;

        // T1: unknown command, then 02 with six payloads, then 02 again
        cs_down(0);
        w = 8'h10 + 8'($urandom_range(0, 200));
        send(w);
        send(8'h02);
        for (int k = 0; k < 6; k++) send(8'hA0 + 8'(k));
        send(8'h02);
        drain("t1_drain");
        cs_up(0);
        chk("t1_no_frame_error", fe_cnt[0], 32'd0);

        // T3: partial word after a command, then a fresh command
        cs_down(0);
        send(8'h01);
        send_word(0, 8'($urandom), 1'b1, 5);
        cs_up(0);
        chk("t3_frame_error_cycles", fe_cnt[0], 32'd1);
        chk("t3_no_push", {31'd0, v0}, 32'd0);
        cs_down(0);
        send(8'h02);
        send(8'($urandom));
        drain("t3_drain");
        cs_up(0);

        // T4: overflow with a stalled consumer, framing kept across drops
        rdy0 = 1'b0;
        cs_down(0);
        send(8'h01);
        for (int k = 0; k < 5; k++) send(8'($urandom));
        repeat (8) @(posedge clock);
        #2;
        chk("t4_valid_held", {31'd0, v0}, 32'd1);
        chk("t4_head_data", {24'd0, d0}, 32'h01);
        chk("t4_overflow", {31'd0, ov0}, {31'd0, exp_ovf});
        rdy0 = 1'b1;
        drain("t4_drain");
        send(8'($urandom));
        drain("t4_idx5_drain");
        chk("t4_overflow_sticky", {31'd0, ov0}, 32'd1);
        cs_up(0);

        // T2: mode 3 instance and LSB-first instance each receive 0x5A
        cs_down(1);
        cs_down(2);
        send_word(1, 8'h5A, 1'b1, 8);
        send_word(2, 8'h5A, 1'b0, 8);
        repeat (6) @(posedge clock);
        #2;
        chk("t2_m3_valid", {31'd0, v1}, 32'd1);
        chk("t2_m3_data", {24'd0, d1}, 32'h5A);
        chk("t2_m3_is_cmd", {31'd0, ic1}, 32'd1);
        chk("t2_m3_frame_error", fe_cnt[1], 32'd0);
        chk("t2_lsb_valid", {31'd0, v2}, 32'd1);
        chk("t2_lsb_data", {24'd0, d2}, 32'h5A);
        chk("t2_lsb_is_cmd", {31'd0, ic2}, 32'd1);
        chk("t2_lsb_frame_error", fe_cnt[2], 32'd0);
        cs_up(1);
        cs_up(2);

        // T5: full-length CMD_A payload then a command
        cs_down(0);
        send(8'h01);
        for (int k = 0; k < 513; k++) send(8'($urandom));
        send(8'h02);
        drain("t5_drain");
        cs_up(0);

        // T6: reset in the middle of a payload
        cs_down(0);
        send(8'h02);
        for (int k = 0; k < 3; k++) send(8'($urandom));
        drain("t6_pre_drain");
        @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        rem = 0;
        exp_ovf = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("t6_valid", {31'd0, v0}, 32'd0);
        chk("t6_data", {24'd0, d0}, 32'd0);
        chk("t6_is_cmd", {31'd0, ic0}, 32'd0);
        chk("t6_command", {24'd0, c0}, 32'd0);
        chk("t6_index", {16'd0, i0}, 32'd0);
        chk("t6_overflow", {31'd0, ov0}, {31'd0, exp_ovf});
        chk("t6_frame_error", {31'd0, fe0}, 32'd0);
        @(posedge clock);
        #2;
        hwait();
        send(8'h02);
        send(8'($urandom));
        drain("t6_post_drain");
        cs_up(0);

        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_frame_error_total", fe_cnt[0], 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
